// File: rtl/axis_prbs_checker_if.sv
// AXI-Stream beat channel (tvalid/tready/tdata) shared by PRBS generator and checker.
interface axis_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_prbs_checker.sv
// PRBS checker on an AXI-Stream input: searches, verifies, locks and counts bit-word errors.
// Define AXIS_PRBS_CHECKER_SAT_EN to make err_cnt_o/beat_cnt_o saturate instead of wrapping.
module axis_prbs_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int LOCK_CNT   = 4,
    parameter int LOSS_CNT   = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_WIDTH-1:0] poly_i,
    input  logic                 clear_i,
    axis_if.slave                s_axis,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o,
    output logic [CNT_WIDTH-1:0] beat_cnt_o
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 2);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);
    localparam logic [MATCH_W-1:0] LOCK_VAL  = MATCH_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0]  LOSS_LAST = MISS_W'(LOSS_CNT - 1);

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] pred;
    logic [MATCH_W-1:0]    match_cnt;
    logic [MISS_W-1:0]     miss_cnt;
    logic                  beat;

    function automatic logic [DATA_WIDTH-1:0] prbs_next(
        input logic [DATA_WIDTH-1:0] x,
        input logic [DATA_WIDTH-1:0] poly
    );
        return {x[DATA_WIDTH-2:0], ^(x & poly)};
    endfunction

    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
`ifdef AXIS_PRBS_CHECKER_SAT_EN
        return (&c) ? c : c + 1'b1;
`else
        return c + 1'b1;
`endif
    endfunction

    assign s_axis.tready = ~rst_i;
    assign beat          = s_axis.tvalid & s_axis.tready;

    // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= SEARCH;
            pred       <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
            locked_o   <= 1'b0;
            err_o      <= 1'b0;
            err_cnt_o  <= '0;
            beat_cnt_o <= '0;
        end else begin
            err_o <= 1'b0;
            if (beat) begin
                case (state)
                    SEARCH: begin
                        pred      <= prbs_next(s_axis.tdata, poly_i);
                        match_cnt <= '0;
                        state     <= VERIFY;
                    end
                    VERIFY: begin
                        pred <= prbs_next(s_axis.tdata, poly_i);
                        if (s_axis.tdata == pred) begin
                            match_cnt <= match_cnt + 1'b1;
                            if (match_cnt == LOCK_VAL) begin
                                state    <= LOCKED;
                                locked_o <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-running prediction: a corrupted word never reseeds the LFSR.
                        pred       <= prbs_next(pred, poly_i);
                        beat_cnt_o <= cnt_inc(beat_cnt_o);
                        if (s_axis.tdata != pred) begin
                            err_o     <= 1'b1;
                            err_cnt_o <= cnt_inc(err_cnt_o);
                            if (miss_cnt == LOSS_LAST) begin
                                state    <= SEARCH;
                                locked_o <= 1'b0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        locked_o <= 1'b0;
                    end
                endcase
            end
            // Last assignment wins, so a clear coinciding with a counted beat reads 0.
            if (clear_i) begin
                err_cnt_o  <= '0;
                beat_cnt_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axis_prbs_checker.sv
// Directed bench for axis_prbs_checker: lock, single error, loss/relock, gaps, counters, reset.
module tb_axis_prbs_checker;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [15:0] poly;
    logic [15:0] gen;

    logic        locked_a, err_a, locked_b, err_b;
    logic [31:0] err_cnt_a, beat_cnt_a;
    logic [3:0]  err_cnt_b, beat_cnt_b;

    int checks = 0;
    int errors = 0;

    axis_if #(.DATA_WIDTH(16)) axis_a ();
    axis_if #(.DATA_WIDTH(16)) axis_b ();

    axis_prbs_checker dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .poly_i     (poly),
        .clear_i    (clear),
        .s_axis     (axis_a.slave),
        .locked_o   (locked_a),
        .err_o      (err_a),
        .err_cnt_o  (err_cnt_a),
        .beat_cnt_o (beat_cnt_a)
    );

    axis_prbs_checker #(.CNT_WIDTH(4), .LOSS_CNT(32)) dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .poly_i     (poly),
        .clear_i    (clear),
        .s_axis     (axis_b.slave),
        .locked_o   (locked_b),
        .err_o      (err_b),
        .err_cnt_o  (err_cnt_b),
        .beat_cnt_o (beat_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] gen_next(input logic [15:0] x);
        return {x[14:0], ^(x & 16'hB400)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d);
        axis_a.tvalid = v;
        axis_a.tdata  = d;
        axis_b.tvalid = v;
        axis_b.tdata  = d;
    endtask

    task automatic good_beat();
        drive(1'b1, gen);
        tick();
        gen = gen_next(gen);
    endtask

    task automatic bad_beat(input logic [15:0] mask);
        drive(1'b1, gen ^ mask);
        tick();
        gen = gen_next(gen);
    endtask

    initial begin
        logic [31:0] sat_exp;
        int          beats;
        int          cyc;

        rst   = 1'b1;
        clear = 1'b0;
        poly  = 16'hB400;
        gen   = 16'h0001;
        drive(1'b0, 16'h0000);

        // Reset state
        tick();
        check("reset_tready", 32'(axis_a.tready), 32'd0);
        check("reset_locked", 32'(locked_a), 32'd0);
        check("reset_err", 32'(err_a), 32'd0);
        check("reset_err_cnt", err_cnt_a, 32'd0);
        check("reset_beat_cnt", beat_cnt_a, 32'd0);
        rst = 1'b0;
        tick();
        check("tready_after_reset", 32'(axis_a.tready), 32'd1);

        // Lock: locked_o rises right after beat 6
        for (int i = 1; i <= 6; i++) begin
            good_beat();
            check($sformatf("lock_beat%0d", i), 32'(locked_a), 32'(i == 6));
        end
        check("lock_err_cnt", err_cnt_a, 32'd0);

        // Single error on beat 20
        for (int i = 7; i <= 19; i++) begin
            good_beat();
            check($sformatf("clean_err_beat%0d", i), 32'(err_a), 32'd0);
        end
        bad_beat(16'h0001);
        check("single_err_pulse", 32'(err_a), 32'd1);
        check("single_err_locked", 32'(locked_a), 32'd1);
        good_beat();
        check("single_err_one_pulse", 32'(err_a), 32'd0);
        check("single_err_cnt", err_cnt_a, 32'd1);
        check("single_beat_cnt", beat_cnt_a, 32'd15);

        // Loss of lock after 8 consecutive bad words, then relock
        for (int k = 1; k <= 8; k++) begin
            bad_beat(16'h5A3C);
            check($sformatf("loss_err%0d", k), 32'(err_a), 32'd1);
            check($sformatf("loss_locked%0d", k), 32'(locked_a), 32'(k < 8));
        end
        check("loss_err_cnt", err_cnt_a, 32'd9);
        check("loss_beat_cnt", beat_cnt_a, 32'd23);
        for (int i = 1; i <= 6; i++) begin
            good_beat();
            check($sformatf("relock_beat%0d", i), 32'(locked_a), 32'(i == 6));
            check($sformatf("relock_err%0d", i), 32'(err_a), 32'd0);
        end

        // Reset from lock, then tvalid 1-0-0-1 gaps with garbage data on idle cycles
        rst = 1'b1;
        drive(1'b0, 16'h0000);
        tick();
        check("gap_reset_locked", 32'(locked_a), 32'd0);
        check("gap_reset_beat_cnt", beat_cnt_a, 32'd0);
        rst   = 1'b0;
        beats = 0;
        cyc   = 0;
        while (beats < 100 && cyc < 1000) begin
            if ((cyc % 4 == 0) || (cyc % 4 == 3)) begin
                good_beat();
                beats++;
            end else begin
                drive(1'b0, ~gen);
                tick();
            end
            check($sformatf("gap_err_cyc%0d", cyc), 32'(err_a), 32'd0);
            cyc++;
        end
        check("gap_beats_done", 32'(beats), 32'd100);
        check("gap_locked", 32'(locked_a), 32'd1);
        check("gap_beat_cnt", beat_cnt_a, 32'd94);
        check("gap_err_cnt", err_cnt_a, 32'd0);

        // Reset asserted mid-stream right after an error beat
        bad_beat(16'h0001);
        check("pre_reset_err", 32'(err_a), 32'd1);
        rst = 1'b1;
        drive(1'b1, gen);
        #1;
        check("midreset_tready", 32'(axis_a.tready), 32'd0);
        tick();
        check("midreset_locked", 32'(locked_a), 32'd0);
        check("midreset_err", 32'(err_a), 32'd0);
        check("midreset_err_cnt", err_cnt_a, 32'd0);
        check("midreset_beat_cnt", beat_cnt_a, 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            good_beat();
            check($sformatf("postreset_lock_a%0d", i), 32'(locked_a), 32'(i == 6));
            check($sformatf("postreset_lock_b%0d", i), 32'(locked_b), 32'(i == 6));
        end

        // 4-bit counters with 20 errors while locked (LOSS_CNT=32 keeps dut_b locked)
        for (int k = 1; k <= 20; k++) begin
            bad_beat(16'h0001);
        end
`ifdef AXIS_PRBS_CHECKER_SAT_EN
        sat_exp = 32'd15;
`else
        sat_exp = 32'd4;
`endif
        check("cnt4_locked", 32'(locked_b), 32'd1);
        check("cnt4_err_cnt", 32'(err_cnt_b), sat_exp);
        check("cnt4_beat_cnt", 32'(beat_cnt_b), sat_exp);

        // Clear coinciding with an error beat wins; state is untouched
        clear = 1'b1;
        bad_beat(16'h0001);
        clear = 1'b0;
        check("clear_err_pulse", 32'(err_b), 32'd1);
        check("clear_err_cnt_b", 32'(err_cnt_b), 32'd0);
        check("clear_beat_cnt_b", 32'(beat_cnt_b), 32'd0);
        check("clear_locked_b", 32'(locked_b), 32'd1);
        check("clear_err_cnt_a", err_cnt_a, 32'd0);
        bad_beat(16'h0001);
        check("after_clear_err_cnt_b", 32'(err_cnt_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
